// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter: round-robin arbiter that shares one bitwise datapath
// between NREQ requesters. The result lands in a single-entry output register
// with a valid/ready handshake.
// Optional build macro AND_ARB_OPSEL_EN adds per-requester op selects
// (00=AND, 01=OR, 10=XOR, 11=NAND) plus a registered rsp_op output.
module and_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef AND_ARB_OPSEL_EN
    input  logic [2*NREQ-1:0]     req_op,
    output logic [1:0]            rsp_op,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
`ifdef AND_ARB_OPSEL_EN
    logic [1:0]        rsp_op_q, rsp_op_d;
    logic [1:0]        op_sel;
`endif

    logic              grant_found;
    int unsigned       grant_int;
    logic [IDW-1:0]    grant_idx;
    logic              can_accept;
    logic              transfer;
    logic [WIDTH-1:0]  opnd_a, opnd_b, result;

    // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0
    always_comb begin
        int unsigned ptr_int;
        int unsigned idx;
        grant_found = 1'b0;
        grant_int   = 0;
        ptr_int     = 32'(rr_ptr_q);
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr_int + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_int   = idx;
            end
        end
        grant_idx = grant_int[IDW-1:0];
    end

    // Grant generation; no grant is issued while reset is asserted
    always_comb begin
        can_accept = (state_q == IDLE) || rsp_ready;
        transfer   = grant_found && can_accept && rst_n;
        req_ready  = '0;
        if (transfer) begin
            req_ready[grant_int] = 1'b1;
        end
    end

    // Shared datapath: operand mux followed by the selected bitwise op
    always_comb begin
        opnd_a = req_a[grant_int*WIDTH +: WIDTH];
        opnd_b = req_b[grant_int*WIDTH +: WIDTH];
`ifdef AND_ARB_OPSEL_EN
        op_sel = req_op[grant_int*2 +: 2];
        case (op_sel)
            2'b00:   result = opnd_a & opnd_b;
            2'b01:   result = opnd_a | opnd_b;
            2'b10:   result = opnd_a ^ opnd_b;
            default: result = ~(opnd_a & opnd_b);
        endcase
`else
        result = opnd_a & opnd_b;
`endif
    end

    // Next-state logic for the output register and the priority pointer
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
`ifdef AND_ARB_OPSEL_EN
        rsp_op_d   = rsp_op_q;
`endif
        if (transfer) begin
            state_d    = FULL;
            rsp_data_d = result;
            rsp_id_d   = grant_idx;
`ifdef AND_ARB_OPSEL_EN
            rsp_op_d   = op_sel;
`endif
            rr_ptr_d   = (grant_int == NREQ - 1) ? '0 : IDW'(grant_int + 1);
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
`ifdef AND_ARB_OPSEL_EN
            rsp_op_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
`ifdef AND_ARB_OPSEL_EN
            rsp_op_q   <= rsp_op_d;
`endif
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef AND_ARB_OPSEL_EN
    assign rsp_op    = rsp_op_q;
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Scoreboard bench for and_unit_arbiter (WIDTH=8, NREQ=4).
// The driver pushes hand-computed results; the monitor pops on each
// accepted response (rsp_valid & rsp_ready sampled at negedge).
module tb_and_unit_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
`ifdef AND_ARB_OPSEL_EN
    logic [2*NREQ-1:0]     req_op;
    logic [1:0]            rsp_op;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
        logic [1:0]       op;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Per-requester AND results for the fixed operand set below
    logic [WIDTH-1:0] and_res [NREQ];

    and_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef AND_ARB_OPSEL_EN
        .req_op    (req_op),
        .rsp_op    (rsp_op),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [IDW-1:0] id, input logic [1:0] op);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every response the consumer accepts
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
`ifdef AND_ARB_OPSEL_EN
                    chk("rsp_op", 32'(rsp_op), 32'(e.op));
`endif
                end
            end
        end
    end

    // Driver: directed vectors
    initial begin
        // Operands: req0 FF&81=81, req1 AA&0F=0A, req2 F0&3C=30, req3 0F&FF=0F
        req_a = {8'h0F, 8'hF0, 8'hAA, 8'hFF};
        req_b = {8'hFF, 8'h3C, 8'h0F, 8'h81};
        and_res[0] = 8'h81;
        and_res[1] = 8'h0A;
        and_res[2] = 8'h30;
        and_res[3] = 8'h0F;
`ifdef AND_ARB_OPSEL_EN
        req_op = '0;
`endif
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;

        // Reset held for 2 cycles with every requester valid
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);

        // First grant after release goes to requester 0
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);
        push(8'h81, 2'd0, 2'b00);
        tick();
        chk("first_rsp_valid", 32'(rsp_valid), 32'h1);
        req_valid = '0;
        tick();

        // Single request from requester 2
        req_valid = 4'b0100;
        #1;
        chk("single_grant", 32'(req_ready), 32'b0100);
        push(8'h30, 2'd2, 2'b00);
        tick();
        req_valid = '0;
        tick();

        // Pointer now 3: wrap to 0 then skip to 1, idle cycles in between
        req_valid = 4'b0011;
        #1;
        chk("wrap_grant0", 32'(req_ready), 32'b0001);
        push(8'h81, 2'd0, 2'b00);
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'b0011;
        #1;
        chk("skip_grant1", 32'(req_ready), 32'b0010);
        push(8'h0A, 2'd1, 2'b00);
        tick();
        req_valid = '0;
        tick();

        // Pointer now 2: requester 3 alone moves pointer back to 0
        req_valid = 4'b1000;
        #1;
        chk("grant3", 32'(req_ready), 32'b1000);
        push(8'h0F, 2'd3, 2'b00);
        tick();
        req_valid = '0;
        tick();

        // Round robin with all requesters valid and consumer always ready
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            push(and_res[k % 4], IDW'(k % 4), 2'b00);
            tick();
        end

        // Backpressure: requester 3 result held for 5 cycles
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h0F);
            chk("bp_rsp_id", 32'(rsp_id), 32'h3);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0001);
        push(8'h81, 2'd0, 2'b00);
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'h1);
        req_valid = '0;
        tick();
        tick();

        // Reset mid-operation discards the held result and resets the pointer
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        chk("mid_full", 32'(rsp_valid), 32'h1);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_data", 32'(rsp_data), 32'h0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        push(8'h81, 2'd0, 2'b00);
        tick();
        req_valid = '0;
        tick();

`ifdef AND_ARB_OPSEL_EN
        // Requester 1 (AA, 0F): XOR -> A5, NAND -> F5
        req_op    = 8'b0000_1000;
        req_valid = 4'b0010;
        #1;
        chk("op_xor_grant", 32'(req_ready), 32'b0010);
        push(8'hA5, 2'd1, 2'b10);
        tick();
        req_op = 8'b0000_1100;
        #1;
        chk("op_nand_grant", 32'(req_ready), 32'b0010);
        push(8'hF5, 2'd1, 2'b11);
        tick();
        req_valid = '0;
        req_op    = '0;
        tick();
`endif

        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
Shares one WIDTH-bit combinational bitwise-AND datapath between NREQ requesters. A round-robin arbiter selects one requester per cycle and passes its operands through the AND datapath. The result goes into a single-entry output register with a valid/ready handshake. The block sits between requester pipelines and downstream consumers wherever AND logic is too costly to replicate.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), width of requester ID (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
rsp_valid  out  1  result register holds valid data
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  registered result
rsp_id  out  IDW  index of requester that produced rsp_data

Behaviour:
- Reset (rst_n=0 at posedge): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=IDLE. req_ready is combinational and forced to 0 while rst_n=0.
- States:
  - IDLE: output register empty.
  - FULL: rsp_valid=1, holding a result.
- can_accept = (state==IDLE) | (state==FULL & rsp_ready).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping NREQ-1 -> 0. The first set bit is the winner g.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
  - With no req_valid set, req_ready = 0.
- Transfer: occurs on a posedge with req_valid[g] & req_ready[g]. On a transfer:
  - rsp_data <= req_a[g] & req_b[g]
  - rsp_id <= g
  - rsp_valid <= 1
  - state <= FULL
  - rr_ptr <= (g==NREQ-1) ? 0 : g+1
- Latency: result is visible on rsp_data exactly 1 cycle after the accept edge.
- FULL & rsp_ready & no transfer: rsp_valid <= 0, state <= IDLE. rsp_data and rsp_id hold their values.
- FULL & !rsp_ready: rsp_data, rsp_id and rsp_valid are stable. All req_ready = 0.
- FULL & rsp_ready & new transfer in the same cycle: result replaced back-to-back, rsp_valid stays 1. Sustained throughput is 1 result/cycle.
- rr_ptr changes only on a transfer. An idle cycle does not move priority.
- Fairness: with all requesters valid continuously and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transfers.
- Requester protocol: a requester must hold req_valid and its operands stable until accepted. The block does not latch unaccepted requests.
- Reset mid-operation: any held result is discarded (rsp_valid=0 next cycle) and no grant is issued in the reset cycle.
- rsp_id is zero-extended when NREQ is not a power of two. IDW is at least 1.

Optional Feature:
AND_ARB_OPSEL_EN
- Defined: adds port req_op (in, 2*NREQ) with per-requester op selects 00=AND, 01=OR, 10=XOR, 11=NAND. Adds port rsp_op (out, 2), registered with rsp_data. The selected op is applied to the winner's operands; reset value of rsp_op is 00.
- Undefined: ports req_op and rsp_op are absent and the datapath is AND only. Timing and handshake are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0. After release, first grant goes to requester 0.
- Single request, WIDTH=8, NREQ=4: req_valid=0100, req_a[2]=8'hF0, req_b[2]=8'h3C, rsp_ready=1 -> req_ready=0100 at accept; next cycle rsp_data=8'h30, rsp_id=2, rsp_valid=1.
- Round-robin: req_valid=1111 held, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; rsp_valid=1 every cycle after the first.
- Backpressure: result held with rsp_ready=0 for 5 cycles while req_valid=1111 -> rsp_data and rsp_id stable, req_ready=0000. Raising rsp_ready -> new grant in the same cycle, rsp_valid never drops.
- Pointer wrap and skip: rr_ptr=3 after a grant to 2, req_valid=0011 -> grant 0, then 1. Idle cycles in between leave rr_ptr unchanged.
- With AND_ARB_OPSEL_EN: req_a=8'hAA, req_b=8'h0F, op=10 -> rsp_data=8'hA5, rsp_op=10. With op=11 -> rsp_data=8'hF5.
